// File: rtl/pa_dtu_pcfifo_rdr_pkg.sv
// rtl/pa_dtu_pcfifo_rdr_pkg.sv - shared DTU defines for the PC-FIFO dump reader
package pa_dtu_pcfifo_rdr_pkg;

  // PC-FIFO geometry and its debug-register read port
  localparam int          TDT_PCFIFO_DEPTH     = 8;
  localparam int          TDT_PCFIFO_PTR_WIDTH = 3;
  localparam logic [11:0] TDT_PCFIFO_ADDR      = 12'hfe2;

  // Dump reader FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_PUSH = 2'd2,
    ST_DONE = 2'd3
  } rdr_state_e;

endpackage

// File: rtl/pa_dtu_pcfifo_rdr.sv
// rtl/pa_dtu_pcfifo_rdr.sv - drains the PC FIFO entry by entry onto a valid/ready dump stream
module pa_dtu_pcfifo_rdr
  import pa_dtu_pcfifo_rdr_pkg::*;
#(
  parameter int          DEPTH       = TDT_PCFIFO_DEPTH,
  parameter logic [11:0] PCFIFO_ADDR = TDT_PCFIFO_ADDR
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        dm_dtu_dump_req,
  input  logic        rtu_dtu_halted,
  input  logic        cp0_dtu_pcfifo_frz,
  input  logic [31:0] pcfifo_regs_data,
  output logic        rdr_dtu_rreg,
  output logic [11:0] rdr_dtu_addr,
  output logic        pcdump_vld,
  output logic [31:0] pcdump_data,
  output logic        pcdump_first,
  output logic        pcdump_last,
  input  logic        pcdump_rdy,
  output logic        rdr_busy,
  output logic        rdr_done,
  output logic        rdr_err
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  rdr_state_e       r_state;
  rdr_state_e       w_next_state;
  logic [PTR_W-1:0] r_cnt;
  logic [31:1]      r_hold;   // bit0 is the oldest-entry marker and is never forwarded
  logic             r_err;
  logic             r_rej;    // one-cycle done/err pulse for a dropped request

  logic w_req_ok;
  logic w_abort;
  logic w_start;
  logic w_rreg;
  logic w_cnt_inc;
  logic w_set_err;
  logic w_reject;
  logic w_push;

  // A dump may only start, and may only continue, while halted and not frozen
  assign w_req_ok = rtu_dtu_halted && !cp0_dtu_pcfifo_frz;
  assign w_abort  = !w_req_ok;

  // Next-state and per-cycle control decode
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_rreg       = 1'b0;
    w_cnt_inc    = 1'b0;
    w_set_err    = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dm_dtu_dump_req) begin
          if (w_req_ok) begin
            w_start      = 1'b1;
            w_next_state = ST_READ;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (w_abort) begin
          // Suppress the strobe so a frozen/unhalted FIFO pointer is left alone
          w_set_err    = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_rreg = 1'b1;
          if ((r_cnt == '0) && !pcfifo_regs_data[0]) begin
            // Read pointer was not on the oldest entry: nothing trustworthy to dump
            w_set_err    = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            if ((r_cnt != '0) && pcfifo_regs_data[0]) begin
              w_set_err = 1'b1;
            end
            w_next_state = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        if (w_abort) begin
          w_set_err    = 1'b1;
          w_next_state = ST_DONE;
        end else if (pcdump_rdy) begin
          w_cnt_inc    = 1'b1;
          w_next_state = (r_cnt == LAST_IDX) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Entry counter: cleared on an accepted request, advanced on each accepted entry
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Holding register captures the FIFO word in the same cycle as the read strobe
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_hold <= '0;
    end else if (w_rreg) begin
      r_hold <= pcfifo_regs_data[31:1];
    end
  end

  // Sticky dump error plus the one-cycle rejection pulse
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_err <= 1'b0;
      r_rej <= 1'b0;
    end else begin
      r_rej <= w_reject;
      if (w_start) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // An aborting PUSH withdraws valid so the dropped entry cannot be handshaken
  assign w_push       = (r_state == ST_PUSH) && !w_abort;

  assign rdr_dtu_rreg = w_rreg;
  assign rdr_dtu_addr = w_rreg ? PCFIFO_ADDR : 12'h000;
  assign pcdump_vld   = w_push;
  assign pcdump_data  = {r_hold, 1'b0};
  assign pcdump_first = w_push && (r_cnt == '0);
  assign pcdump_last  = w_push && (r_cnt == LAST_IDX);
  assign rdr_busy     = (r_state != ST_IDLE);
  assign rdr_done     = (r_state == ST_DONE) || r_rej;
  assign rdr_err      = r_err || r_rej;

endmodule

// File: tb/tb_pa_dtu_pcfifo_rdr.sv
// tb/tb_pa_dtu_pcfifo_rdr.sv - scoreboard bench for the PC-FIFO dump reader
module tb_pa_dtu_pcfifo_rdr;

  typedef struct {
    logic [31:0] data;
    logic        first;
    logic        last;
  } ent_t;

  typedef struct {
    logic err;
    int   lat;
    int   nrreg;
  } done_t;

  logic        clk;
  logic        cpurst_b;
  logic        dm_dtu_dump_req;
  logic        rtu_dtu_halted;
  logic        cp0_dtu_pcfifo_frz;
  logic [31:0] pcfifo_regs_data;
  logic        rdr_dtu_rreg;
  logic [11:0] rdr_dtu_addr;
  logic        pcdump_vld;
  logic [31:0] pcdump_data;
  logic        pcdump_first;
  logic        pcdump_last;
  logic        pcdump_rdy;
  logic        rdr_busy;
  logic        rdr_done;
  logic        rdr_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_cyc  = 0;
  int rreg_cnt = 0;
  bit rreg_pend = 0;

  ent_t  exp_q[$];
  done_t done_q[$];
  ent_t  e;
  done_t d;

  // PC FIFO model: fixed contents, read pointer advanced by the read strobe
  logic [31:0] fifo_mem [8];
  int          rd_cnt = 0;
  int          base   = 0;

  assign pcfifo_regs_data = fifo_mem[3'(rd_cnt - base)];

  pa_dtu_pcfifo_rdr dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (cpurst_b),
    .dm_dtu_dump_req    (dm_dtu_dump_req),
    .rtu_dtu_halted     (rtu_dtu_halted),
    .cp0_dtu_pcfifo_frz (cp0_dtu_pcfifo_frz),
    .pcfifo_regs_data   (pcfifo_regs_data),
    .rdr_dtu_rreg       (rdr_dtu_rreg),
    .rdr_dtu_addr       (rdr_dtu_addr),
    .pcdump_vld         (pcdump_vld),
    .pcdump_data        (pcdump_data),
    .pcdump_first       (pcdump_first),
    .pcdump_last        (pcdump_last),
    .pcdump_rdy         (pcdump_rdy),
    .rdr_busy           (rdr_busy),
    .rdr_done           (rdr_done),
    .rdr_err            (rdr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rdr_dtu_rreg && !cp0_dtu_pcfifo_frz) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues
  always @(negedge clk) begin
    if (!cpurst_b) begin
      rreg_cnt  = 0;
      rreg_pend = 0;
    end else begin
      if (rdr_dtu_rreg) begin
        rreg_cnt++;
        chk("rreg_addr", {20'h0, rdr_dtu_addr}, 32'h0000_0fe2);
        chk("rreg_without_handshake", {31'h0, rreg_pend}, 32'h0);
        rreg_pend = 1;
      end
      if (pcdump_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", pcdump_data, 32'hdead_beef);
        end else begin
          e = exp_q[0];
          chk("entry_data", pcdump_data, e.data);
          chk("entry_first", {31'h0, pcdump_first}, {31'h0, e.first});
          chk("entry_last", {31'h0, pcdump_last}, {31'h0, e.last});
          if (pcdump_rdy) begin
            void'(exp_q.pop_front());
            rreg_pend = 0;
          end
        end
      end
      if (rdr_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          d = done_q.pop_front();
          chk("done_latency", cyc - req_cyc, d.lat);
          chk("done_err", {31'h0, rdr_err}, {31'h0, d.err});
          chk("rreg_count", rreg_cnt, d.nrreg);
        end
        rreg_cnt  = 0;
        rreg_pend = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // FIFO holding 0x100..0x10e, oldest entry marked by bit0
  task automatic fill_lin();
    for (int i = 0; i < 8; i++) fifo_mem[i] = 32'h100 + 32'(2 * i);
    fifo_mem[0] = fifo_mem[0] | 32'h1;
    base = rd_cnt;
  endtask

  task automatic push_lin(input int n);
    ent_t x;
    for (int i = 0; i < n; i++) begin
      x.data  = 32'h100 + 32'(2 * i);
      x.first = (i == 0);
      x.last  = (i == 7);
      exp_q.push_back(x);
    end
  endtask

  task automatic push_done(input logic err, input int lat, input int nrreg);
    done_t x;
    x.err   = err;
    x.lat   = lat;
    x.nrreg = nrreg;
    done_q.push_back(x);
  endtask

  task automatic issue();
    dm_dtu_dump_req = 1'b1;
    req_cyc         = cyc;
    step(1);
    dm_dtu_dump_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((done_q.size() != 0 || rdr_busy) && n < 200) begin
      step(1);
      n++;
    end
    chk({name, "_timeout"}, {31'h0, (n >= 200)}, 32'h0);
    chk({name, "_entries_left"}, exp_q.size(), 32'h0);
    exp_q.delete();
    done_q.delete();
  endtask

  initial begin
    cpurst_b           = 1'b0;
    dm_dtu_dump_req    = 1'b0;
    rtu_dtu_halted     = 1'b0;
    cp0_dtu_pcfifo_frz = 1'b0;
    pcdump_rdy         = 1'b1;
    fill_lin();
    step(3);

    // Reset state
    chk("rst_vld", {31'h0, pcdump_vld}, 32'h0);
    chk("rst_rreg", {31'h0, rdr_dtu_rreg}, 32'h0);
    chk("rst_addr", {20'h0, rdr_dtu_addr}, 32'h0);
    chk("rst_data", pcdump_data, 32'h0);
    chk("rst_busy", {31'h0, rdr_busy}, 32'h0);
    chk("rst_done", {31'h0, rdr_done}, 32'h0);
    chk("rst_err", {31'h0, rdr_err}, 32'h0);
    cpurst_b = 1'b1;
    step(2);

    // Full dump with rdy held high
    rtu_dtu_halted = 1'b1;
    fill_lin();
    push_lin(8);
    push_done(1'b0, 17, 8);
    issue();
    wait_done("full_dump");

    // Consumer stalls 5 cycles on entry 3
    fill_lin();
    push_lin(8);
    push_done(1'b0, 22, 8);
    issue();
    step(7);
    pcdump_rdy = 1'b0;
    step(5);
    pcdump_rdy = 1'b1;
    wait_done("stall_dump");

    // Request while not halted is dropped with a done/err pulse
    rtu_dtu_halted = 1'b0;
    push_done(1'b1, 1, 0);
    issue();
    wait_done("rej_halt");
    step(1);
    chk("rej_err_not_sticky", {31'h0, rdr_err}, 32'h0);

    // Request while frozen is dropped too
    rtu_dtu_halted     = 1'b1;
    cp0_dtu_pcfifo_frz = 1'b1;
    push_done(1'b1, 1, 0);
    issue();
    wait_done("rej_frz");
    cp0_dtu_pcfifo_frz = 1'b0;

    // Freeze after the second entry is accepted
    fill_lin();
    push_lin(2);
    push_done(1'b1, 6, 2);
    issue();
    step(4);
    cp0_dtu_pcfifo_frz = 1'b1;
    wait_done("frz_abort");
    cp0_dtu_pcfifo_frz = 1'b0;
    step(1);
    chk("err_sticky", {31'h0, rdr_err}, 32'h1);
    chk("idle_after_abort", {31'h0, rdr_busy}, 32'h0);

    // First read lacks the oldest-entry marker
    fill_lin();
    fifo_mem[0] = 32'h200;
    push_done(1'b1, 2, 1);
    issue();
    wait_done("misaligned");

    // Oldest marker on a later entry flags an error but the dump completes
    fill_lin();
    fifo_mem[4] = fifo_mem[4] | 32'h1;
    push_lin(8);
    push_done(1'b1, 17, 8);
    issue();
    wait_done("late_marker");

    // Clean dump clears the sticky error
    fill_lin();
    push_lin(8);
    push_done(1'b0, 17, 8);
    issue();
    wait_done("err_clear_dump");

    // Reset during PUSH, then a full dump afterwards
    fill_lin();
    pcdump_rdy = 1'b0;
    push_lin(1);
    issue();
    step(2);
    cpurst_b = 1'b0;
    #1;
    chk("arst_vld", {31'h0, pcdump_vld}, 32'h0);
    chk("arst_busy", {31'h0, rdr_busy}, 32'h0);
    chk("arst_first", {31'h0, pcdump_first}, 32'h0);
    exp_q.delete();
    done_q.delete();
    step(2);
    cpurst_b   = 1'b1;
    pcdump_rdy = 1'b1;
    step(1);
    fill_lin();
    push_lin(8);
    push_done(1'b0, 17, 8);
    issue();
    wait_done("post_reset_dump");

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
